// File: rtl/kbd_pkg.sv
// Shared scan-code constants, FSM state types and the set-2 to ASCII lookup
// for the PS/2 keyboard front end.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_ESC    = 8'h76;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_e;

    typedef enum logic [1:0] {
        BASE,
        BRK,
        EXT,
        EXT_BRK
    } dec_state_e;

    // Returns {hit, ascii}; letters are upper-cased when shift is held.
    function automatic logic [8:0] sc2ascii(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        logic       hit;
        logic       letter;
        ch     = '0;
        hit    = 1'b1;
        letter = 1'b1;
        case (code)
            8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
            8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
            8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
            8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
            8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
            8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
            8'h35: ch = "y";  8'h1A: ch = "z";
            default: begin
                letter = 1'b0;
                case (code)
                    8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
                    8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
                    8'h3E: ch = "8";  8'h46: ch = "9";  8'h29: ch = 8'h20;
                    default: hit = 1'b0;
                endcase
            end
        endcase
        if (letter && shift) begin
            ch = ch - 8'h20;
        end
        return {hit, ch};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect,
// frame FSM, inactivity timeout and optional odd-parity check (PS2_KBD_PARITY_CHECK_EN).
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code,
    output logic       code_stb,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    rx_state_e     state_q, state_d;
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    code_q, code_d;
    logic          code_stb_q, code_stb_d;
    logic          frame_err_q, frame_err_d;
    logic          fall, ps2_dat, timeout_hit, parity_ok;

    assign fall        = clk_prev_q & ~clk_sync_q[1];
    assign ps2_dat     = dat_sync_q[1];
    assign timeout_hit = (state_q == SHIFT) && !fall && (to_cnt_q == TO_MAX);

`ifdef PS2_KBD_PARITY_CHECK_EN
    assign parity_ok = ^shift_q;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fall && !ps2_dat) state_d = SHIFT;
            SHIFT: if ((fall && bit_cnt_q == 4'd9) || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Data and parity share one 9-bit shifter; after the parity edge
    // shift_q[7:0] holds the byte and shift_q[8] the parity bit.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        code_d      = code_q;
        code_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        to_cnt_d    = fall ? '0 : ((to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1);
        case (state_q)
            IDLE: if (fall && !ps2_dat) bit_cnt_d = '0;
            SHIFT: begin
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd9) begin
                        shift_d = {ps2_dat, shift_q[8:1]};
                    end else if (ps2_dat && parity_ok) begin
                        code_d     = shift_q[7:0];
                        code_stb_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            clk_prev_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            code_q      <= '0;
            code_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            code_q      <= code_d;
            code_stb_q  <= code_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign code      = code_q;
    assign code_stb  = code_stb_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard front end: scan code set 2 make/break decoder producing one
// ASCII strobe per keypress. Optional parity check via PS2_KBD_PARITY_CHECK_EN.
module ps2_kbd
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] kbd_data,
    output logic       kbd_valid,
    output logic       kbd_done,
    output logic       kbd_reset,
    output logic       frame_err
);

    logic [7:0] code;
    logic       code_stb;
    logic [8:0] lookup;

    dec_state_e state_q, state_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d, done_q, done_d, reset_q, reset_d;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk_i (ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .code      (code),
        .code_stb  (code_stb),
        .frame_err (frame_err)
    );

    assign lookup = sc2ascii(code, lshift_q | rshift_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BASE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (code_stb) begin
            case (state_q)
                BASE: begin
                    if (code == SC_BREAK)    state_d = BRK;
                    else if (code == SC_EXT) state_d = EXT;
                end
                EXT:     state_d = (code == SC_BREAK) ? EXT_BRK : BASE;
                default: state_d = BASE;
            endcase
        end
    end

    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        data_d   = '0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        reset_d  = 1'b0;
        if (code_stb) begin
            case (state_q)
                BASE: begin
                    if (code == SC_LSHIFT) begin
                        lshift_d = 1'b1;
                    end else if (code == SC_RSHIFT) begin
                        rshift_d = 1'b1;
                    end else if (code == SC_ENTER) begin
                        {valid_d, done_d, data_d} = {2'b11, ASCII_CR};
                    end else if (code == SC_ESC) begin
                        {valid_d, reset_d, data_d} = {2'b11, ASCII_ESC};
                    end else if (code != SC_BREAK && code != SC_EXT && lookup[8]) begin
                        {valid_d, data_d} = {1'b1, lookup[7:0]};
                    end
                end
                BRK: begin
                    if (code == SC_LSHIFT) lshift_d = 1'b0;
                    if (code == SC_RSHIFT) rshift_d = 1'b0;
                end
                EXT: if (code == SC_ENTER) {valid_d, done_d, data_d} = {2'b11, ASCII_CR};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            reset_q  <= 1'b0;
        end else begin
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            reset_q  <= reset_d;
        end
    end

    assign kbd_data  = data_q;
    assign kbd_valid = valid_q;
    assign kbd_done  = done_q;
    assign kbd_reset = reset_q;

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed self-checking bench for ps2_kbd: drives PS/2 frames and checks
// the decoded ASCII events, frame errors, timeout and mid-frame reset.
module tb_ps2_kbd;

    localparam int unsigned TO   = 200;
    localparam time         HALF = 200ns;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [7:0] kbd_data;
    logic       kbd_valid, kbd_done, kbd_reset, frame_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned valid_cnt = 0, err_cnt = 0, bad_qual = 0, long_pulse = 0;
    logic [7:0]  last_data = '0;
    logic        last_done = 1'b0, last_reset = 1'b0, prev_valid = 1'b0, prev_err = 1'b0;

    ps2_kbd #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk_i (ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_done  (kbd_done),
        .kbd_reset (kbd_reset),
        .frame_err (frame_err)
    );

    always #5ns clk = ~clk;

    always @(negedge clk) begin
        if (kbd_valid) begin
            valid_cnt++;
            last_data  = kbd_data;
            last_done  = kbd_done;
            last_reset = kbd_reset;
        end
        if (frame_err) err_cnt++;
        if (((kbd_done | kbd_reset) & ~kbd_valid) | (kbd_done & kbd_reset)) bad_qual++;
        if ((kbd_valid & prev_valid) | (frame_err & prev_err)) long_pulse++;
        prev_valid = kbd_valid;
        prev_err   = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] frame, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ps2_data_i = frame[i];
            #HALF ps2_clk_i = 1'b0;
            #HALF ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
    endtask

    task automatic send_code(input logic [7:0] c, input logic bad_par = 1'b0, input logic stop = 1'b1);
        logic par;
        par = ~(^c) ^ bad_par;
        send_bits({stop, par, c, 1'b0}, 11);
        #HALF;
    endtask

    // Checks the events produced since the counter snapshot.
    task automatic expect_evt(input string tag, input int unsigned v0, input int unsigned e0,
                              input int unsigned nv, input int unsigned ne,
                              input logic [7:0] d = 8'h00, input logic dn = 1'b0, input logic rs = 1'b0);
        repeat (10) @(posedge clk);
        check({tag, "_nvalid"}, valid_cnt - v0, nv);
        check({tag, "_nerr"}, err_cnt - e0, ne);
        if (nv != 0) begin
            check({tag, "_data"}, {24'h0, last_data}, {24'h0, d});
            check({tag, "_done"}, {31'h0, last_done}, {31'h0, dn});
            check({tag, "_reset"}, {31'h0, last_reset}, {31'h0, rs});
        end
    endtask

    initial begin
        int unsigned v0, e0;

        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, kbd_valid}, 32'h0);
        check("rst_data", {24'h0, kbd_data}, 32'h0);
        check("rst_flags", {29'h0, kbd_done, kbd_reset, frame_err}, 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h1C);
        expect_evt("make_a", v0, e0, 1, 0, 8'h61);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'hF0); send_code(8'h1C);
        expect_evt("break_a", v0, e0, 0, 0);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h12); send_code(8'h1C); send_code(8'hF0);
        send_code(8'h1C); send_code(8'hF0); send_code(8'h12);
        expect_evt("lshift_A", v0, e0, 1, 0, 8'h41);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h1C);
        expect_evt("unshift_a", v0, e0, 1, 0, 8'h61);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h59); send_code(8'h1A);
        expect_evt("rshift_Z", v0, e0, 1, 0, 8'h5A);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h16);
        expect_evt("shift_digit", v0, e0, 1, 0, 8'h31);
        send_code(8'hF0); send_code(8'h59);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h1A); send_code(8'h1A);
        expect_evt("typematic_z", v0, e0, 2, 0, 8'h7A);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h5A);
        expect_evt("enter", v0, e0, 1, 0, 8'h0D, 1'b1, 1'b0);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'hE0); send_code(8'h5A);
        expect_evt("kp_enter", v0, e0, 1, 0, 8'h0D, 1'b1, 1'b0);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'hE0); send_code(8'hF0); send_code(8'h5A);
        send_code(8'hE0); send_code(8'h75);
        expect_evt("ext_ignored", v0, e0, 0, 0);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h76);
        expect_evt("esc", v0, e0, 1, 0, 8'h1B, 1'b0, 1'b1);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h29);
        expect_evt("space", v0, e0, 1, 0, 8'h20);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h0E);
        expect_evt("unmapped", v0, e0, 0, 0);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h16, 1'b1);
`ifdef PS2_KBD_PARITY_CHECK_EN
        expect_evt("bad_parity", v0, e0, 0, 1);
`else
        expect_evt("bad_parity", v0, e0, 1, 0, 8'h31);
`endif

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h1C, 1'b0, 1'b0);
        expect_evt("bad_stop", v0, e0, 0, 1);

        v0 = valid_cnt; e0 = err_cnt;
        send_bits({2'b11, 8'h45, 1'b0}, 5);
        repeat (TO - 60) @(posedge clk);
        #1 check("pre_timeout_err", err_cnt - e0, 0);
        repeat (100) @(posedge clk);
        #1 check("timeout_err", err_cnt - e0, 1);
        check("timeout_valid", valid_cnt - v0, 0);

        v0 = valid_cnt; e0 = err_cnt;
        send_code(8'h45);
        expect_evt("post_timeout_0", v0, e0, 1, 0, 8'h30);

        v0 = valid_cnt; e0 = err_cnt;
        send_bits({2'b11, 8'h1C, 1'b0}, 6);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_valid", {31'h0, kbd_valid}, 32'h0);
        check("midrst_ferr", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        repeat (TO + 50) @(posedge clk);
        send_code(8'h29);
        expect_evt("after_rst_space", v0, e0, 1, 0, 8'h20);

        check("qualifier_rule", bad_qual, 0);
        check("single_cycle_pulses", long_pulse, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
